// File: rtl/team_06_i2s_tx.sv
// I2S transmitter: one-entry sample buffer, internal bclk/lrclk, MSB-first one-bit-delayed framing.
// Sample accepted 1 cycle after valid&&ready; ready stays low until the next frame load empties the buffer.
module team_06_i2s_tx #(
  parameter int DATA_WIDTH = 8,
  parameter int SLOT_WIDTH = 16,
  parameter int BCLK_DIV   = 4
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] sample_in,
  input  logic                  sample_valid,
  output logic                  sample_ready,
  output logic                  bclk,
  output logic                  lrclk,
  output logic                  sdata,
  output logic                  underrun
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam int BIT_W = $clog2(SLOT_WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] hold_q, frame_q;
  logic                  full_q;
  logic [DIV_W-1:0]      div_cnt;
  logic [BIT_W-1:0]      bit_cnt, bit_nxt;
  logic                  div_wrap, fall, slot_wrap, load, accept, sbit;

  assign sample_ready = ~full_q;

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    div_wrap  = (div_cnt == DIV_W'(BCLK_DIV - 1));
    fall      = (state_q == RUN) && en && div_wrap && bclk;
    slot_wrap = fall && (bit_cnt == BIT_W'(SLOT_WIDTH - 1));
    bit_nxt   = slot_wrap ? '0 : bit_cnt + BIT_W'(1);
    accept    = sample_valid && !full_q;
    case (state_q)
      IDLE: begin
        if (en) begin
          state_d = RUN;
          load    = 1'b1;
        end
      end
      RUN: begin
        if (!en) state_d = IDLE;
        // Right slot ending (lrclk 1->0) starts a new frame.
        else if (slot_wrap && lrclk) load = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Slot position p carries frame[DATA_WIDTH-p]; position 0 is the I2S delay bit.
  always_comb begin
    sbit = 1'b0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (bit_nxt == BIT_W'(DATA_WIDTH - i)) sbit = frame_q[i];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q  <= IDLE;
      hold_q   <= '0;
      frame_q  <= '0;
      full_q   <= 1'b0;
      div_cnt  <= '0;
      bit_cnt  <= '0;
      bclk     <= 1'b0;
      lrclk    <= 1'b0;
      sdata    <= 1'b0;
      underrun <= 1'b0;
    end else begin
      state_q  <= state_d;
      underrun <= load && !full_q;

      if (load && full_q) full_q <= 1'b0;
      else if (accept)    full_q <= 1'b1;
      if (accept) hold_q <= sample_in;

      if (load)                         frame_q <= full_q ? hold_q : '0;
      else if (state_q == RUN && !en)   frame_q <= '0;

      if (state_q == RUN && en) begin
        div_cnt <= div_wrap ? '0 : div_cnt + DIV_W'(1);
        if (div_wrap) bclk <= ~bclk;
        if (fall) begin
          bit_cnt <= bit_nxt;
          sdata   <= sbit;
          if (slot_wrap) lrclk <= ~lrclk;
        end
      end else begin
        div_cnt <= '0;
        bit_cnt <= '0;
        bclk    <= 1'b0;
        lrclk   <= 1'b0;
        sdata   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_team_06_i2s_tx.sv
// Directed bench for team_06_i2s_tx: default instance plus a SLOT_WIDTH=9, BCLK_DIV=1 instance.
module tb_team_06_i2s_tx;

  logic       clk = 1'b0;
  logic       nrst, en, sample_valid, sample_ready, bclk, lrclk, sdata, underrun;
  logic [7:0] sample_in;
  logic       p_en, p_valid, p_ready, p_bclk, p_lrclk, p_sdata, p_underrun;
  logic [7:0] p_sample_in;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  team_06_i2s_tx u_dut (
    .clk(clk), .nrst(nrst), .en(en), .sample_in(sample_in), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .bclk(bclk), .lrclk(lrclk), .sdata(sdata), .underrun(underrun)
  );

  team_06_i2s_tx #(.DATA_WIDTH(8), .SLOT_WIDTH(9), .BCLK_DIV(1)) u_par (
    .clk(clk), .nrst(nrst), .en(p_en), .sample_in(p_sample_in), .sample_valid(p_valid),
    .sample_ready(p_ready), .bclk(p_bclk), .lrclk(p_lrclk), .sdata(p_sdata), .underrun(p_underrun)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    en = 0; p_en = 0; sample_valid = 0; p_valid = 0; sample_in = 0; p_sample_in = 0;
    nrst = 0;
    repeat (3) tick;
    nrst = 1;
    tick;
  endtask

  task automatic write_sample(input logic [7:0] v);
    int n = 0;
    sample_in = v; sample_valid = 1;
    while (!sample_ready && n < 1000) begin tick; n++; end
    checks++;
    if (sample_ready !== 1'b1) begin errors++; $display("FAIL write_timeout: sample_ready=%b required 1", sample_ready); end
    tick;
    sample_valid = 0;
  endtask

  task automatic test_reset;
    bit bad = 0;
    do_reset;
    checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b want 1", sample_ready); end
    checks++; if (bclk !== 1'b0)  begin errors++; $display("FAIL rst_bclk: got %b want 0", bclk); end
    checks++; if (lrclk !== 1'b0) begin errors++; $display("FAIL rst_lrclk: got %b want 0", lrclk); end
    checks++; if (sdata !== 1'b0) begin errors++; $display("FAIL rst_sdata: got %b want 0", sdata); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b want 0", underrun); end
    for (int t = 0; t < 500; t++) begin
      if (bclk !== 1'b0 || lrclk !== 1'b0 || sdata !== 1'b0 || sample_ready !== 1'b1) bad = 1;
      tick;
    end
    checks++; if (bad) begin errors++; $display("FAIL idle_quiet: outputs toggled while en=0, want bclk/lrclk/sdata=0 ready=1"); end
  endtask

  task automatic test_reset_mid;
    do_reset;
    write_sample(8'h91);
    en = 1; tick;
    for (int t = 0; t < 13; t++) begin
      if (t == 0) begin sample_in = 8'h22; sample_valid = 1; end
      if (t == 1) sample_valid = 0;
      tick;
    end
    checks++; if ({bclk, sdata, sample_ready} !== 3'b110) begin errors++; $display("FAIL midrun_pre: bclk,sdata,ready=%b want 110", {bclk, sdata, sample_ready}); end
    nrst = 0;
    #2;
    checks++; if ({sample_ready, bclk, lrclk, sdata, underrun} !== 5'b10000) begin
      errors++; $display("FAIL midrun_async_rst: ready,bclk,lrclk,sdata,underrun=%b want 10000", {sample_ready, bclk, lrclk, sdata, underrun}); end
    en = 0;
    tick;
    nrst = 1;
    tick;
  endtask

  task automatic test_single;
    logic [15:0] left = '0, right = '0;
    do_reset;
    write_sample(8'hA7);
    en = 1; tick;
    for (int t = 0; t <= 257; t++) begin
      if (t % 8 == 4 && t < 128) left[15 - (t - 4) / 8] = sdata;
      if (t % 8 == 4 && t >= 128 && t < 256) right[15 - (t - 132) / 8] = sdata;
      if (t == 0) begin checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL single_no_ur: got %b want 0", underrun); end end
      if (t == 3) begin checks++; if (bclk !== 1'b0) begin errors++; $display("FAIL single_bclk_t3: got %b want 0", bclk); end end
      if (t == 4) begin checks++; if (bclk !== 1'b1) begin errors++; $display("FAIL single_bclk_t4: got %b want 1", bclk); end end
      if (t == 8) begin checks++; if (sdata !== 1'b1) begin errors++; $display("FAIL single_msb_t8: got %b want 1", sdata); end end
      if (t == 127) begin checks++; if (lrclk !== 1'b0) begin errors++; $display("FAIL single_lr_t127: got %b want 0", lrclk); end end
      if (t == 128) begin checks++; if (lrclk !== 1'b1) begin errors++; $display("FAIL single_lr_t128: got %b want 1", lrclk); end end
      if (t == 255) begin checks++; if (lrclk !== 1'b1) begin errors++; $display("FAIL single_lr_t255: got %b want 1", lrclk); end end
      if (t == 256) begin checks++; if ({lrclk, underrun} !== 2'b01) begin errors++; $display("FAIL single_t256: lrclk,underrun=%b want 01", {lrclk, underrun}); end end
      if (t == 257) begin checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL single_ur_pulse: got %b want 0", underrun); end end
      tick;
    end
    checks++; if (left !== 16'h5380) begin errors++; $display("FAIL single_left: got %h want 5380", left); end
    checks++; if (right !== 16'h5380) begin errors++; $display("FAIL single_right: got %h want 5380", right); end
    en = 0; tick;
  endtask

  task automatic test_back_to_back;
    logic [15:0] f2 = '0;
    bit ur = 0;
    do_reset;
    write_sample(8'hA7);
    en = 1; tick;
    for (int t = 0; t <= 384; t++) begin
      if (underrun) ur = 1;
      if (t >= 260 && t % 8 == 4) f2[15 - (t - 260) / 8] = sdata;
      if (t == 0) begin
        checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_t0: got %b want 1", sample_ready); end
        sample_in = 8'hD6; sample_valid = 1;
      end
      if (t == 1) begin
        sample_valid = 0;
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_t1: got %b want 0", sample_ready); end
      end
      if (t == 255) begin checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_t255: got %b want 0", sample_ready); end end
      if (t == 256) begin checks++; if (sample_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_t256: got %b want 1", sample_ready); end end
      tick;
    end
    checks++; if (f2 !== 16'h6B00) begin errors++; $display("FAIL b2b_frame2: got %h want 6b00", f2); end
    checks++; if (ur) begin errors++; $display("FAIL b2b_underrun: got 1 want 0"); end
    en = 0; tick;
  endtask

  task automatic test_underrun;
    logic [15:0] f2 = '0;
    bit any1 = 0;
    do_reset;
    en = 1; tick;
    for (int t = 0; t <= 384; t++) begin
      if (t < 256 && sdata) any1 = 1;
      if (t >= 260 && t % 8 == 4) f2[15 - (t - 260) / 8] = sdata;
      if (t == 0) begin checks++; if (underrun !== 1'b1) begin errors++; $display("FAIL ur_entry: got %b want 1", underrun); end end
      if (t == 1) begin checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_pulse_len: got %b want 0", underrun); end end
      if (t == 100) begin sample_in = 8'h55; sample_valid = 1; end
      if (t == 101) begin
        sample_valid = 0;
        checks++; if (sample_ready !== 1'b0) begin errors++; $display("FAIL ur_accept: ready=%b want 0", sample_ready); end
      end
      if (t == 256) begin checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL ur_second_load: got %b want 0", underrun); end end
      tick;
    end
    checks++; if (any1) begin errors++; $display("FAIL ur_silent_frame: sdata went 1, want 0"); end
    checks++; if (f2 !== 16'h2A80) begin errors++; $display("FAIL ur_frame2: got %h want 2a80", f2); end
    en = 0; tick;
  endtask

  task automatic test_disable;
    logic [15:0] left = '0;
    do_reset;
    write_sample(8'hFF);
    en = 1; tick;
    for (int t = 0; t < 36; t++) begin
      if (t == 0) begin sample_in = 8'h3C; sample_valid = 1; end
      if (t == 1) sample_valid = 0;
      tick;
    end
    checks++; if ({bclk, sdata} !== 2'b11) begin errors++; $display("FAIL dis_pre: bclk,sdata=%b want 11", {bclk, sdata}); end
    en = 0; tick;
    checks++; if ({bclk, lrclk, sdata, sample_ready} !== 4'b0000) begin
      errors++; $display("FAIL dis_off: bclk,lrclk,sdata,ready=%b want 0000", {bclk, lrclk, sdata, sample_ready}); end
    repeat (5) tick;
    en = 1; tick;
    for (int t = 0; t < 128; t++) begin
      if (t % 8 == 4) left[15 - (t - 4) / 8] = sdata;
      if (t == 0) begin checks++; if ({underrun, sample_ready} !== 2'b01) begin
        errors++; $display("FAIL dis_reentry: underrun,ready=%b want 01", {underrun, sample_ready}); end end
      tick;
    end
    checks++; if (left !== 16'h1E00) begin errors++; $display("FAIL dis_frame: got %h want 1e00", left); end
    en = 0; tick;
  endtask

  task automatic test_param;
    logic [8:0] left = '0, right = '0;
    do_reset;
    checks++; if (p_ready !== 1'b1) begin errors++; $display("FAIL par_ready: got %b want 1", p_ready); end
    p_sample_in = 8'hFF; p_valid = 1; tick; p_valid = 0;
    p_en = 1; tick;
    for (int t = 0; t <= 36; t++) begin
      if (t % 2 == 1 && t < 18) left[8 - (t - 1) / 2] = p_sdata;
      if (t % 2 == 1 && t > 18) right[17 - (t - 1) / 2] = p_sdata;
      if (t == 0) begin checks++; if ({p_bclk, p_underrun} !== 2'b00) begin errors++; $display("FAIL par_t0: bclk,underrun=%b want 00", {p_bclk, p_underrun}); end end
      if (t == 1) begin checks++; if (p_bclk !== 1'b1) begin errors++; $display("FAIL par_bclk_t1: got %b want 1", p_bclk); end end
      if (t == 2) begin checks++; if ({p_bclk, p_sdata} !== 2'b01) begin errors++; $display("FAIL par_t2: bclk,sdata=%b want 01", {p_bclk, p_sdata}); end end
      if (t == 17) begin checks++; if (p_lrclk !== 1'b0) begin errors++; $display("FAIL par_lr_t17: got %b want 0", p_lrclk); end end
      if (t == 18) begin checks++; if (p_lrclk !== 1'b1) begin errors++; $display("FAIL par_lr_t18: got %b want 1", p_lrclk); end end
      if (t == 35) begin checks++; if (p_lrclk !== 1'b1) begin errors++; $display("FAIL par_lr_t35: got %b want 1", p_lrclk); end end
      if (t == 36) begin checks++; if ({p_lrclk, p_underrun} !== 2'b01) begin errors++; $display("FAIL par_t36: lrclk,underrun=%b want 01", {p_lrclk, p_underrun}); end end
      tick;
    end
    checks++; if (left !== 9'h0FF) begin errors++; $display("FAIL par_left: got %h want 0ff", left); end
    checks++; if (right !== 9'h0FF) begin errors++; $display("FAIL par_right: got %h want 0ff", right); end
    p_en = 0; tick;
  endtask

  initial begin
    test_reset;
    test_reset_mid;
    test_single;
    test_back_to_back;
    test_underrun;
    test_disable;
    test_param;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
